// File: rtl/queen_solver_ctrl_pkg.sv
// Shared types and helpers for the N-Queens backtracking controller.
package queen_solver_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRY,
    ST_BACK,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Index width for a vector of n entries; never below one bit.
  function automatic int idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/queen_solver_ctrl_if.sv
// Stack-side bus of the solver: push/pop strobes, entry to push and current top entry.
interface queen_solver_ctrl_if #(
  parameter int W = 3
);
  logic           push;
  logic           pop;
  logic [2*W-1:0] wdata;
  logic [2*W-1:0] top;

  modport master (output push, output pop, output wdata, input top);
  modport slave  (input push, input pop, input wdata, output top);
endinterface

// File: rtl/queen_solver_ctrl_safety.sv
// Occupancy index decode and attack test for one board square.
module queen_solver_ctrl_safety
  import queen_solver_ctrl_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3,
  localparam int CW = idx_bits(N),
  localparam int DW = idx_bits(2 * N - 1)
) (
  input  logic [W-1:0]   row,
  input  logic [W:0]     col,
  input  logic [N-1:0]   col_mask,
  input  logic [2*N-2:0] diag,
  input  logic [2*N-2:0] anti,
  output logic [CW-1:0]  col_idx,
  output logic [DW-1:0]  diag_idx,
  output logic [DW-1:0]  anti_idx,
  output logic           safe
);

  assign col_idx  = CW'(col);
  assign diag_idx = DW'(row) + DW'(col);
  // Wraps modulo 2^DW, which lands in range whenever col < N.
  assign anti_idx = DW'(row) + DW'(N - 1) - DW'(col);
  assign safe     = ~col_mask[col_idx] & ~diag[diag_idx] & ~anti[anti_idx];

endmodule

// File: rtl/queen_solver_ctrl.sv
// Backtracking N-Queens controller: uses an external stack as placement history,
// then drains it to stream the first solution, rows N-1 down to 0.
//
// state | meaning
// IDLE  | after reset, waiting for start
// TRY   | test candidate (r,c); push on safe, advance column otherwise
// BACK  | pop last placement, resume at its next column
// DRAIN | stream and pop the N solution entries
// DONE  | result held in done/found, waiting for start
module queen_solver_ctrl
  import queen_solver_ctrl_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3,
  localparam int CW = idx_bits(N),
  localparam int DW = idx_bits(2 * N - 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  queen_solver_ctrl_if.master        stk,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic                       sol_valid,
  output logic [2*W-1:0]             sol_data,
  output logic [15:0]                push_count
);

  localparam logic [W:0]   C_END  = (W + 1)'(N);
  localparam logic [W-1:0] R_LAST = W'(N - 1);

  state_t         state;
  logic [W-1:0]   r;
  logic [W:0]     c;
  logic [W-1:0]   k;
  logic [N-1:0]   col_mask;
  logic [2*N-2:0] diag;
  logic [2*N-2:0] anti;

  logic [W-1:0]   top_row, top_col, chk_row;
  logic [W:0]     chk_col;
  logic [CW-1:0]  col_idx;
  logic [DW-1:0]  diag_idx, anti_idx;
  logic           safe;

  assign top_row = stk.top[2*W-1:W];
  assign top_col = stk.top[W-1:0];

  // In BACK the mask bits to release belong to the entry on top of the stack.
  assign chk_row = (state == ST_BACK) ? top_row : r;
  assign chk_col = (state == ST_BACK) ? {1'b0, top_col} : c;

  queen_solver_ctrl_safety #(.N(N), .W(W)) u_safety (
    .row      (chk_row),
    .col      (chk_col),
    .col_mask (col_mask),
    .diag     (diag),
    .anti     (anti),
    .col_idx  (col_idx),
    .diag_idx (diag_idx),
    .anti_idx (anti_idx),
    .safe     (safe)
  );

  // Stack strobes are decoded from the current state so each pop is visible
  // on stack_top in the very next cycle, which BACK and DRAIN rely on.
  assign stk.push  = (state == ST_TRY) && (c != C_END) && safe;
  assign stk.pop   = (state == ST_BACK) || (state == ST_DRAIN);
  assign stk.wdata = stk.push ? {r, c[W-1:0]} : '0;
  assign sol_valid = (state == ST_DRAIN);
  assign sol_data  = sol_valid ? stk.top : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      r          <= '0;
      c          <= '0;
      k          <= '0;
      col_mask   <= '0;
      diag       <= '0;
      anti       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      push_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r          <= '0;
            c          <= '0;
            k          <= '0;
            col_mask   <= '0;
            diag       <= '0;
            anti       <= '0;
            push_count <= '0;
            done       <= 1'b0;
            found      <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_TRY;
          end
        end
        ST_TRY: begin
          if (c == C_END) begin
            if (r == '0) begin
              done     <= 1'b1;
              found    <= 1'b0;
              busy     <= 1'b0;
              col_mask <= '0;
              diag     <= '0;
              anti     <= '0;
              state    <= ST_DONE;
            end else begin
              state <= ST_BACK;
            end
          end else if (safe) begin
            col_mask[col_idx] <= 1'b1;
            diag[diag_idx]    <= 1'b1;
            anti[anti_idx]    <= 1'b1;
            if (push_count != 16'hFFFF) push_count <= push_count + 16'd1;
            if (r == R_LAST) begin
              k     <= '0;
              state <= ST_DRAIN;
            end else begin
              r <= r + 1'b1;
              c <= '0;
            end
          end else begin
            c <= c + 1'b1;
          end
        end
        ST_BACK: begin
          col_mask[col_idx] <= 1'b0;
          diag[diag_idx]    <= 1'b0;
          anti[anti_idx]    <= 1'b0;
          r                 <= top_row;
          c                 <= {1'b0, top_col} + 1'b1;
          state             <= ST_TRY;
        end
        ST_DRAIN: begin
          if (k == R_LAST) begin
            done     <= 1'b1;
            found    <= 1'b1;
            busy     <= 1'b0;
            col_mask <= '0;
            diag     <= '0;
            anti     <= '0;
            state    <= ST_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queen_solver_ctrl.sv
// Directed bench: one controller plus behavioural stack per board size (8,4,3,2,1).
module tb_queen_solver_ctrl;

  localparam int NC = 5;
  localparam int NS [NC] = '{8, 4, 3, 2, 1};
  localparam int WS [NC] = '{3, 2, 2, 1, 1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_v [NC];

  wire        busy_v      [NC];
  wire        done_v      [NC];
  wire        found_v     [NC];
  wire        sol_valid_v [NC];
  wire [5:0]  sol_data_v  [NC];
  wire [15:0] pc_v        [NC];
  wire        push_v      [NC];
  wire        pop_v       [NC];
  wire [31:0] depth_v     [NC];
  wire [31:0] viol_v      [NC];

  int checks = 0;
  int errors = 0;
  int nsol;
  int sols [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : gen_cfg
    localparam int NN = NS[g];
    localparam int WW = WS[g];

    queen_solver_ctrl_if #(.W(WW)) stk ();

    logic              busy, done, found, sol_valid;
    logic [2*WW-1:0]   sol_data;
    logic [15:0]       push_count;
    logic [2*WW-1:0]   mem [NN];
    int                depth = 0;
    int                viol = 0;

    queen_solver_ctrl #(.N(NN), .W(WW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[g]),
      .stk        (stk),
      .busy       (busy),
      .done       (done),
      .found      (found),
      .sol_valid  (sol_valid),
      .sol_data   (sol_data),
      .push_count (push_count)
    );

    // Stack with mem[0] as top; also flags push&pop together, overflow, underflow.
    always @(posedge clk) begin
      if (reset) begin
        depth <= 0;
      end else if (stk.push) begin
        for (int i = NN - 1; i > 0; i--) mem[i] <= mem[i-1];
        mem[0] <= stk.wdata;
        depth  <= depth + 1;
        if (stk.pop || depth >= NN) viol <= viol + 1;
      end else if (stk.pop) begin
        for (int i = 0; i < NN - 1; i++) mem[i] <= mem[i+1];
        if (depth == 0) viol <= viol + 1;
        else depth <= depth - 1;
      end
    end

    assign stk.top        = (depth != 0) ? mem[0] : '0;
    assign busy_v[g]      = busy;
    assign done_v[g]      = done;
    assign found_v[g]     = found;
    assign sol_valid_v[g] = sol_valid;
    assign sol_data_v[g]  = 6'(sol_data);
    assign pc_v[g]        = push_count;
    assign push_v[g]      = stk.push;
    assign pop_v[g]       = stk.pop;
    assign depth_v[g]     = 32'(depth);
    assign viol_v[g]      = 32'(viol);
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference search with pairwise attack test, counting safe placements.
  function automatic int model_pushes(input int n);
    int qc [8];
    int r = 0;
    int c = 0;
    int cnt = 0;
    bit ok;
    for (int i = 0; i < 8; i++) qc[i] = 0;
    for (int guard = 0; guard < 100000; guard++) begin
      if (c == n) begin
        if (r == 0) return cnt;
        r--;
        c = qc[r] + 1;
      end else begin
        ok = 1'b1;
        for (int i = 0; i < r; i++)
          if (qc[i] == c || qc[i] - c == r - i || c - qc[i] == r - i) ok = 1'b0;
        if (ok) begin
          qc[r] = c;
          cnt++;
          if (r == n - 1) return cnt;
          r++;
          c = 0;
        end else begin
          c++;
        end
      end
    end
    return -1;
  endfunction

  task automatic check_idle(input int idx, input string tag);
    check_eq($sformatf("%s_busy_n%0d", tag, NS[idx]), busy_v[idx], 0);
    check_eq($sformatf("%s_done_n%0d", tag, NS[idx]), done_v[idx], 0);
    check_eq($sformatf("%s_found_n%0d", tag, NS[idx]), found_v[idx], 0);
    check_eq($sformatf("%s_solv_n%0d", tag, NS[idx]), sol_valid_v[idx], 0);
    check_eq($sformatf("%s_sold_n%0d", tag, NS[idx]), sol_data_v[idx], 0);
    check_eq($sformatf("%s_pc_n%0d", tag, NS[idx]), pc_v[idx], 0);
    check_eq($sformatf("%s_push_n%0d", tag, NS[idx]), push_v[idx], 0);
    check_eq($sformatf("%s_pop_n%0d", tag, NS[idx]), pop_v[idx], 0);
    check_eq($sformatf("%s_depth_n%0d", tag, NS[idx]), depth_v[idx], 0);
  endtask

  task automatic run_solve(input int idx, input bit glitch);
    int cyc = 0;
    nsol = 0;
    for (int i = 0; i < 8; i++) sols[i] = -1;
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    check_eq($sformatf("busy_after_start_n%0d", NS[idx]), busy_v[idx], 1);
    while (done_v[idx] !== 1'b1 && cyc < 5000) begin
      if (sol_valid_v[idx]) begin
        if (nsol < 8) sols[nsol] = int'(sol_data_v[idx]);
        nsol++;
      end
      start_v[idx] = glitch && (cyc % 7 == 3);
      @(negedge clk);
      cyc++;
    end
    start_v[idx] = 1'b0;
    check_eq($sformatf("done_reached_n%0d", NS[idx]), done_v[idx], 1);
  endtask

  // cols[row] gives the expected column per row; stream order is row N-1 first.
  task automatic check_result(input int idx, input bit exp_found, input int cols [8],
                              input string tag);
    int n = NS[idx];
    int row;
    check_eq($sformatf("%s_found", tag), found_v[idx], exp_found);
    check_eq($sformatf("%s_busy_end", tag), busy_v[idx], 0);
    check_eq($sformatf("%s_nsol", tag), nsol, exp_found ? n : 0);
    if (exp_found) begin
      for (int j = 0; j < n; j++) begin
        row = n - 1 - j;
        check_eq($sformatf("%s_entry%0d", tag, j), sols[j], (row << WS[idx]) | cols[row]);
      end
    end
    check_eq($sformatf("%s_pc_model", tag), pc_v[idx], model_pushes(n));
    check_eq($sformatf("%s_stack_empty", tag), depth_v[idx], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c8 [8] = '{0, 4, 7, 5, 2, 6, 1, 3};
    int c4 [8] = '{1, 3, 0, 2, 0, 0, 0, 0};
    int c1 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int pc4;

    for (int i = 0; i < NC; i++) start_v[i] = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NC; i++) check_idle(i, "por");

    // Reset held two cycles in the middle of the N=8 search.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("mid_busy_n8", busy_v[0], 1);
    check_eq("mid_depth_nz_n8", depth_v[0] != 0, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle(0, "midrst");

    run_solve(0, 1'b0);
    check_result(0, 1'b1, c8, "n8");

    run_solve(1, 1'b0);
    check_result(1, 1'b1, c4, "n4");
    check_eq("n4_pc_const", pc_v[1], 8);
    pc4 = int'(pc_v[1]);

    run_solve(2, 1'b0);
    check_result(2, 1'b0, c1, "n3");
    run_solve(3, 1'b0);
    check_result(3, 1'b0, c1, "n2");

    run_solve(4, 1'b0);
    check_result(4, 1'b1, c1, "n1");
    check_eq("n1_pc_const", pc_v[4], 1);

    // Restart from DONE with start pulses injected while busy.
    run_solve(1, 1'b1);
    check_result(1, 1'b1, c4, "n4_rerun");
    check_eq("n4_rerun_pc_same", pc_v[1], pc4);

    for (int i = 0; i < NC; i++)
      check_eq($sformatf("stack_protocol_n%0d", NS[i]), viol_v[i], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
